// File: rtl/tft_init_sequencer.sv
// TFT power-up sequencer: sends the init ROM at the slow SPI clock, waits out the
// post-init delay, then passes pixel words through at the fast SPI clock.

module tft_clk_div #(
    parameter int unsigned HALF = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic div_clk
);
    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

    if (HALF < 1) begin : g_bad_half
        $error("tft_clk_div: HALF must be at least 1");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            div_clk <= ~div_clk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module tft_init_sequencer #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned INIT_FREQ      = 10_000,
    parameter int unsigned WORK_FREQ      = 5_000_000,
    parameter int unsigned INIT_DATA_SIZE = 104,
    parameter int unsigned DELAY_MS       = 160,
    parameter int unsigned PTR_BITS       = 25,
    // Init image as a packed constant, entry i = {rs, data16} at bits [17*i +: 17];
    // replaces the hex-file ROM load so no file is read at elaboration or run time.
    parameter logic [17*INIT_DATA_SIZE-1:0] INIT_ROM = '0
) (
    input  logic                MasterCLK,
    input  logic                RST_n,
    input  logic                word_tick,
    input  logic [15:0]         pixel_data,
    output logic [15:0]         out_data,
    output logic                spi_clk,
    output logic                rs,
    output logic                cs_n,
    output logic                init_done,
    output logic [PTR_BITS-1:0] pointer
);
    localparam int unsigned DELAY_TICKS = DELAY_MS * INIT_FREQ / 1000;
    localparam int unsigned END_PTR     = INIT_DATA_SIZE + DELAY_TICKS;
    localparam int unsigned AW          = (INIT_DATA_SIZE > 1) ? $clog2(INIT_DATA_SIZE) : 1;
    localparam int unsigned INIT_HALF   = CLK_FREQ / (2 * INIT_FREQ);
    localparam int unsigned WORK_HALF   = CLK_FREQ / (2 * WORK_FREQ);

    if ((END_PTR >> PTR_BITS) != 0) begin : g_bad_ptr
        $error("tft_init_sequencer: PTR_BITS too narrow for INIT_DATA_SIZE+DELAY_TICKS");
    end

    typedef enum logic [1:0] {
        PH_INIT,
        PH_DELAY,
        PH_WORK
    } phase_t;

    logic                init_clk;
    logic                work_clk;
    logic [PTR_BITS-1:0] ptr;
    phase_t              phase;
    logic [16:0]         rom [INIT_DATA_SIZE];
    logic [AW-1:0]       rom_idx;
    logic [16:0]         rom_word;
    logic [15:0]         nxt_data;
    logic                nxt_rs;
    logic                nxt_cs_n;
    logic                nxt_done;

    tft_clk_div #(.HALF(INIT_HALF)) u_init_div (
        .clk     (MasterCLK),
        .rst_n   (RST_n),
        .div_clk (init_clk)
    );

    tft_clk_div #(.HALF(WORK_HALF)) u_work_div (
        .clk     (MasterCLK),
        .rst_n   (RST_n),
        .div_clk (work_clk)
    );

    always_comb begin
        for (int unsigned i = 0; i < INIT_DATA_SIZE; i++) begin
            rom[i] = INIT_ROM[17*i +: 17];
        end
    end

    always_comb begin
        if (ptr < PTR_BITS'(INIT_DATA_SIZE)) begin
            phase = PH_INIT;
        end else if (ptr < PTR_BITS'(END_PTR)) begin
            phase = PH_DELAY;
        end else begin
            phase = PH_WORK;
        end
    end

    always_comb begin
        rom_idx  = (phase == PH_INIT) ? ptr[AW-1:0] : '0;
        rom_word = rom[rom_idx];
        nxt_data = '0;
        nxt_rs   = 1'b1;
        nxt_cs_n = 1'b1;
        nxt_done = 1'b0;
        case (phase)
            PH_INIT: begin
                nxt_data = rom_word[15:0];
                nxt_rs   = rom_word[16];
                nxt_cs_n = 1'b0;
            end
            PH_DELAY: begin
                nxt_data = '0;
            end
            PH_WORK: begin
                nxt_data = pixel_data;
                nxt_cs_n = 1'b0;
                nxt_done = 1'b1;
            end
            default: begin
                nxt_data = '0;
            end
        endcase
    end

    always_ff @(posedge MasterCLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr       <= '0;
            out_data  <= '0;
            rs        <= 1'b0;
            cs_n      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            if (word_tick && phase != PH_WORK) begin
                ptr <= ptr + 1'b1;
            end
            out_data  <= nxt_data;
            rs        <= nxt_rs;
            cs_n      <= nxt_cs_n;
            init_done <= nxt_done;
        end
    end

    assign spi_clk = init_done ? work_clk : init_clk;
    assign pointer = ptr;
endmodule

// File: tb/tb_tft_init_sequencer.sv
// Bench for tft_init_sequencer: fixed vector table for the init/delay/work walk,
// hand sequences for reset and back-to-back ticks, then random traffic vs a model.

module tb_tft_init_sequencer;
    localparam int unsigned HALF_I  = 5;
    localparam int unsigned HALF_W  = 2;
    localparam int unsigned N_ROM   = 4;
    localparam int unsigned END_PTR = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_tick;
    logic [15:0] pixel_data;
    logic [15:0] out_data;
    logic        spi_clk;
    logic        rs;
    logic        cs_n;
    logic        init_done;
    logic [7:0]  pointer;

    always #5 clk = ~clk;

    tft_init_sequencer #(
        .CLK_FREQ       (100),
        .INIT_FREQ      (10),
        .WORK_FREQ      (25),
        .INIT_DATA_SIZE (4),
        .DELAY_MS       (200),
        .PTR_BITS       (8),
        .INIT_ROM       ({17'h0_0029, 17'h1_0044, 17'h0_002A, 17'h1_0011})
    ) dut (
        .MasterCLK  (clk),
        .RST_n      (rst_n),
        .word_tick  (word_tick),
        .pixel_data (pixel_data),
        .out_data   (out_data),
        .spi_clk    (spi_clk),
        .rs         (rs),
        .cs_n       (cs_n),
        .init_done  (init_done),
        .pointer    (pointer)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [16:0] rom_m [N_ROM] = '{17'h1_0011, 17'h0_002A, 17'h1_0044, 17'h0_0029};
    int          m_ptr;
    int          m_edges;
    logic [15:0] m_out;
    bit          m_rs, m_cs, m_done;

    typedef struct {
        bit          rst;
        bit          tick;
        logic [15:0] pix;
        logic [15:0] e_out;
        bit          e_rs;
        bit          e_cs;
        bit          e_done;
        int          e_ptr;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Divided clocks are free-running from reset release, so their level is a pure
    // function of the number of edges seen since then.
    function automatic bit exp_spi();
        if (m_done) return bit'((m_edges / HALF_W) % 2);
        return bit'((m_edges / HALF_I) % 2);
    endfunction

    task automatic model_edge(input bit rst, input bit tick, input logic [15:0] pix);
        logic [16:0] w;
        if (!rst) begin
            m_ptr = 0; m_edges = 0; m_out = '0; m_rs = 0; m_cs = 1; m_done = 0;
        end else begin
            if (m_ptr < N_ROM) begin
                w = rom_m[m_ptr];
                m_out = w[15:0]; m_rs = w[16]; m_cs = 0; m_done = 0;
            end else if (m_ptr < END_PTR) begin
                m_out = '0; m_rs = 1; m_cs = 1; m_done = 0;
            end else begin
                m_out = pix; m_rs = 1; m_cs = 0; m_done = 1;
            end
            if (tick && m_ptr < END_PTR) m_ptr++;
            m_edges++;
        end
    endtask

    task automatic step(input bit rst, input bit tick, input logic [15:0] pix);
        rst_n = rst; word_tick = tick; pixel_data = pix;
        @(posedge clk);
        model_edge(rst, tick, pix);
        #1;
        n_vec++;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_data"},  32'(out_data),  32'(m_out));
        check({tag, ".rs"},        32'(rs),        32'(m_rs));
        check({tag, ".cs_n"},      32'(cs_n),      32'(m_cs));
        check({tag, ".init_done"}, 32'(init_done), 32'(m_done));
        check({tag, ".pointer"},   32'(pointer),   32'(m_ptr));
        check({tag, ".spi_clk"},   32'(spi_clk),   32'(exp_spi()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 16'h0000, 16'h0011, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 16'h0000, 16'h0011, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 16'h0000, 16'h002A, 0, 0, 0, 2};
        tbl[4]  = '{1, 1, 16'h0000, 16'h0044, 1, 0, 0, 3};
        tbl[5]  = '{1, 1, 16'h0000, 16'h0029, 0, 0, 0, 4};
        tbl[6]  = '{1, 0, 16'h0000, 16'h0000, 1, 1, 0, 4};
        tbl[7]  = '{1, 1, 16'h0000, 16'h0000, 1, 1, 0, 5};
        tbl[8]  = '{1, 1, 16'h0000, 16'h0000, 1, 1, 0, 6};
        tbl[9]  = '{1, 0, 16'hF800, 16'hF800, 1, 0, 1, 6};
        tbl[10] = '{1, 1, 16'h1234, 16'h1234, 1, 0, 1, 6};
        tbl[11] = '{1, 1, 16'hF800, 16'hF800, 1, 0, 1, 6};

        rst_n = 1'b0; word_tick = 1'b0; pixel_data = '0;
        model_edge(0, 0, '0);

        // Reset values, then free-running divider with no ticks
        repeat (3) begin
            step(0, 1, 16'hBEEF);
            check_model("reset");
            check("reset.spi_const", 32'(spi_clk), 32'd0);
            check("reset.cs_const",  32'(cs_n),    32'd1);
        end
        step(1, 0, '0);
        check_model("first_word");
        check("first_word.out", 32'(out_data), 32'h0011);
        for (int i = 0; i < 24; i++) begin
            step(1, 0, '0);
            check_model("divider");
        end

        // Init walk, delay, work, saturation
        step(0, 0, '0);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].tick, tbl[i].pix);
            check($sformatf("tbl%0d.out", i),  32'(out_data),  32'(tbl[i].e_out));
            check($sformatf("tbl%0d.rs", i),   32'(rs),        32'(tbl[i].e_rs));
            check($sformatf("tbl%0d.cs", i),   32'(cs_n),      32'(tbl[i].e_cs));
            check($sformatf("tbl%0d.done", i), 32'(init_done), 32'(tbl[i].e_done));
            check($sformatf("tbl%0d.ptr", i),  32'(pointer),   32'(tbl[i].e_ptr));
            check($sformatf("tbl%0d.spi", i),  32'(spi_clk),   32'(exp_spi()));
        end
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 16'hF800);
            check_model("work_clk");
        end

        // Mid-sequence asynchronous reset at ptr=3
        step(0, 0, '0);
        step(1, 0, '0);
        repeat (3) step(1, 1, '0);
        check("mid.ptr_before", 32'(pointer), 32'd3);
        rst_n = 1'b0;
        #1;
        model_edge(0, 0, '0);
        check("mid.spi",  32'(spi_clk),   32'd0);
        check("mid.out",  32'(out_data),  32'd0);
        check("mid.cs",   32'(cs_n),      32'd1);
        check("mid.done", 32'(init_done), 32'd0);
        check("mid.ptr",  32'(pointer),   32'd0);
        step(0, 1, '0);
        step(1, 0, '0);
        check("mid.rel_out", 32'(out_data), 32'h0011);
        check("mid.rel_rs",  32'(rs),       32'd1);
        check("mid.rel_cs",  32'(cs_n),     32'd0);
        check("mid.rel_ptr", 32'(pointer),  32'd0);

        // Back-to-back ticks
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, '0);
            check($sformatf("b2b.ptr%0d", i), 32'(pointer), 32'(i));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0), bit'($urandom_range(0, 1)), 16'($urandom));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
